sync_fifo_lvl: RTL and testbench

Parametrised synchronous FIFO for the user-project TX/RX datapaths, replacing fixed 8×8 buffers. It uses all 2**ADDR_WIDTH entries and adds an occupancy level, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Producer and consumer share one clock domain.

---
 rtl/sync_fifo_lvl.sv | 93 +++++++++
 tb/tb_sync_fifo_lvl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lvl.sv
// Parametrised single-clock FIFO with occupancy level, threshold flags, flush and sticky errors.
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through data_out.
module sync_fifo_lvl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL    = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL    = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flush suppresses both requests so pointers and level can be cleared cleanly.
  assign wr_ok = wr_en & ~fifo_full  & ~flush;
  assign rd_ok = rd_en & ~fifo_empty & ~flush;

  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == DEPTH_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign almost_full  = (level >= AF_LVL);

  always_ff @(posedge clk) begin
    if (reset_n && wr_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~err_clr) | (wr_en & fifo_full  & ~flush);
      underflow <= (underflow & ~err_clr) | (rd_en & fifo_empty & ~flush);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (!reset_n)
      data_out <= '0;
    else if (rd_ok)
      data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl (DATA_WIDTH=8, ADDR_WIDTH=3).
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       flush = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] level;
  logic       fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_lvl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .flush(flush), .err_clr(err_clr), .level(level),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock with the given requests; q is the word delivered by an accepted read.
  task automatic do_cycle(input logic w, input logic [7:0] d, input logic r, output logic [7:0] q);
    wr_en = w; data_in = d; rd_en = r;
`ifdef SYNC_FIFO_FWFT_EN
    q = data_out;
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    q = data_out;
`endif
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if ({fifo_empty, fifo_full, almost_empty, almost_full} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags got %b exp 1010", {fifo_empty, fifo_full, almost_empty, almost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [7:0] q;
    for (int i = 1; i <= 8; i++) begin
      do_cycle(1'b1, 8'(i), 1'b0, q);
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, i); end
      checks++; if (almost_full !== (i >= 7)) begin errors++; $display("FAIL fill_afull at %0d got %b", i, almost_full); end
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", fifo_full); end
    for (int i = 1; i <= 8; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, q);
      checks++; if (q !== 8'(i)) begin errors++; $display("FAIL drain_data got %h exp %h", q, 8'(i)); end
    end
    checks++; if ({fifo_empty, almost_empty, level} !== {2'b11, 4'd0}) begin
      errors++; $display("FAIL drain_end got e=%b ae=%b lvl=%0d exp 1 1 0", fifo_empty, almost_empty, level); end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] q;
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'h11 + 8'(i), 1'b0, q);
    do_cycle(1'b1, 8'hAA, 1'b0, q);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, q);
      checks++; if (q !== 8'h11 + 8'(i)) begin errors++; $display("FAIL ovf_drain got %h exp %h", q, 8'h11 + 8'(i)); end
    end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", underflow); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL unf_level got %0d exp 0", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL err_clr got %b exp 00", {overflow, underflow}); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] q;
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'h21 + 8'(i), 1'b0, q);
    do_cycle(1'b1, 8'h99, 1'b1, q);
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_both_level got %0d exp 7", level); end
    checks++; if (q !== 8'h21) begin errors++; $display("FAIL full_both_data got %h exp 21", q); end
    for (int i = 1; i < 8; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, q);
      checks++; if (q !== 8'h21 + 8'(i)) begin errors++; $display("FAIL full_both_drain got %h exp %h", q, 8'h21 + 8'(i)); end
    end
    do_cycle(1'b1, 8'h55, 1'b1, q);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL empty_both_level got %0d exp 1", level); end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (q !== 8'h55) begin errors++; $display("FAIL empty_both_data got %h exp 55", q); end
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'h31 + 8'(i), 1'b0, q);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 8'h35 + 8'(i), 1'b1, q);
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL mid_both_level got %0d exp 4", level); end
      checks++; if (q !== 8'h31 + 8'(i)) begin errors++; $display("FAIL mid_both_data got %h exp %h", q, 8'h31 + 8'(i)); end
    end
    for (int i = 2; i < 6; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, q);
      checks++; if (q !== 8'h31 + 8'(i)) begin errors++; $display("FAIL mid_order got %h exp %h", q, 8'h31 + 8'(i)); end
    end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] q;
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, 8'h10 + 8'(i), 1'b0, q);
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL wrap_wlevel got %0d exp 1", level); end
      do_cycle(1'b0, 8'h00, 1'b1, q);
      checks++; if (q !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_data got %h exp %h", q, 8'h10 + 8'(i)); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL wrap_rlevel got %0d exp 0", level); end
    end
  endtask

  task automatic test_flush_reset();
    logic [7:0] q;
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'h41 + 8'(i), 1'b0, q);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL pre_flush_level got %0d exp 5", level); end
    flush = 1'b1;
    do_cycle(1'b1, 8'hEE, 1'b0, q);
    flush = 1'b0;
    checks++; if ({fifo_empty, level} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL flush got e=%b lvl=%0d exp 1 0", fifo_empty, level); end
    @(posedge clk); #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_wr_ignored got %0d exp 0", level); end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL post_flush_unf got %b exp 1", underflow); end
    do_cycle(1'b1, 8'h77, 1'b0, q);
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (q !== 8'h77) begin errors++; $display("FAIL post_flush_data got %h exp 77", q); end
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'h61 + 8'(i), 1'b0, q);
    reset_n = 1'b0;
    do_cycle(1'b1, 8'hEE, 1'b1, q);
    reset_n = 1'b1;
    checks++; if ({fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow, level} !== {6'b101000, 4'd0}) begin
      errors++; $display("FAIL midrst got e=%b f=%b ae=%b af=%b ov=%b un=%b lvl=%0d exp 1 0 1 0 0 0 0",
        fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow, level); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", data_out); end
`endif
  endtask

  task automatic test_mode_latency();
    logic [7:0] q;
    do_cycle(1'b1, 8'h5A, 1'b0, q);
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL fwft_show got %h exp 5a", data_out); end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fwft_ack got %b exp 1", fifo_empty); end
`else
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL std_pre got %h exp 00", data_out); end
    @(posedge clk); #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL std_idle got %h exp 00", data_out); end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL std_read got %h exp 5a", data_out); end
    do_cycle(1'b1, 8'h6B, 1'b0, q);
    @(posedge clk); #1;
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL std_hold got %h exp 5a", data_out); end
    do_cycle(1'b0, 8'h00, 1'b1, q);
    checks++; if (data_out !== 8'h6B) begin errors++; $display("FAIL std_next got %h exp 6b", data_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_wrap();
    test_flush_reset();
    test_mode_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
